bus_fifo_write_arbiter: RTL and testbench

//   Shares the write side of one bus_fifo among NUM_REQ producers. Round-robin grant,

---
 rtl/bus_fifo_arb_pkg.sv | 18 +
 rtl/rr_priority_pick.sv | 33 +++
 rtl/bus_fifo_write_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_fifo_write_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fifo_arb_pkg.sv
// Shared state type and sizing helpers for the bus_fifo write-side arbiter.
package bus_fifo_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request after last_winner, wrapping modulo NUM_REQ.
module rr_priority_pick
    import bus_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_winner,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop, so no path can infer a latch.
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        // Offsets 1..NUM_REQ visit last_winner itself last, giving it lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_winner) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req && req[ID_W'(idx)]) begin
                any_req = 1'b1;
                winner  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_fifo_write_arbiter.sv
// Shares the write port of one bus_fifo among NUM_REQ producers; round-robin,
// grant held per packet or MAX_BURST beats, stalls on FIFO_FULL without releasing.
module bus_fifo_write_arbiter
    import bus_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*WIDTH-1:0]      REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_LAST,
    output logic [NUM_REQ-1:0]            REQ_ACK,
    output logic                          FIFO_STROBE,
    output logic [WIDTH-1:0]              FIFO_DATA,
    input  logic                          FIFO_FULL,
    output logic                          GRANT_VALID,
    output logic [id_width(NUM_REQ)-1:0]  GRANT_ID
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = cnt_width(MAX_BURST);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_e       state;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  last_winner;
    logic [CNT_W-1:0] beat_cnt;

    logic [ID_W-1:0]  pick_id;
    logic             pick_any;

    logic             owner_req;
    logic             owner_last;
    logic [WIDTH-1:0] owner_data;
    logic             accept;
    logic             burst_end;
    logic             release_grant;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req         (REQ),
        .last_winner (last_winner),
        .winner      (pick_id),
        .any_req     (pick_any)
    );

    // Select the current owner's request, last flag and data.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                owner_req  = REQ[i];
                owner_last = REQ_LAST[i];
                owner_data = REQ_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    // Gating with RESET_N keeps the write port quiet while reset is asserted,
    // even though the state registers only clear on the next edge.
    assign accept    = RESET_N && (state == GRANTED) && owner_req && !FIFO_FULL;
    assign burst_end = (int'(beat_cnt) + 1 == MAX_BURST);

    // A FULL stall alone never releases; only LAST, burst limit or abandon do.
    assign release_grant = (state == GRANTED) &&
                           (!owner_req || (accept && (owner_last || burst_end)));

    always_comb begin
        REQ_ACK     = '0;
        FIFO_STROBE = accept;
        FIFO_DATA   = '0;
        if (accept) begin
            REQ_ACK[grant_id] = 1'b1;
            FIFO_DATA         = owner_data;
        end
    end

    assign GRANT_VALID = grant_valid;
    assign GRANT_ID    = grant_id;

    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_winner <= LAST_ID;
            beat_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state       <= GRANTED;
                        grant_valid <= 1'b1;
                        grant_id    <= pick_id;
                        last_winner <= pick_id;
                        beat_cnt    <= '0;
                    end
                end
                GRANTED: begin
                    if (release_grant) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        beat_cnt    <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                    grant_id    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_fifo_write_arbiter.sv
// Directed bench for bus_fifo_write_arbiter: per-requester beat queues feed REQ,
// each accepted beat is logged and compared against hand-written expectations.
module tb_bus_fifo_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 16;

    logic                     CLK = 1'b0;
    logic                     RESET_N;
    logic [NUM_REQ-1:0]       REQ;
    logic [NUM_REQ*WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]       REQ_LAST;
    logic [NUM_REQ-1:0]       REQ_ACK;
    logic                     FIFO_STROBE;
    logic [WIDTH-1:0]         FIFO_DATA;
    logic                     FIFO_FULL;
    logic                     GRANT_VALID;
    logic [1:0]               GRANT_ID;

    int checks = 0;
    int errors = 0;

    // Each queue entry is {last, data}.
    logic [8:0] q [NUM_REQ][$];
    logic [7:0] log_data [$];
    logic [1:0] log_id   [$];
    logic [7:0] exp_data [$];
    logic [1:0] exp_id   [$];
    logic [NUM_REQ-1:0] ack_seen;

    bus_fifo_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .REQ         (REQ),
        .REQ_DATA    (REQ_DATA),
        .REQ_LAST    (REQ_LAST),
        .REQ_ACK     (REQ_ACK),
        .FIFO_STROBE (FIFO_STROBE),
        .FIFO_DATA   (FIFO_DATA),
        .FIFO_FULL   (FIFO_FULL),
        .GRANT_VALID (GRANT_VALID),
        .GRANT_ID    (GRANT_ID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] beat;
        REQ      = '0;
        REQ_LAST = '0;
        REQ_DATA = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (q[i].size() > 0) begin
                beat                   = q[i][0];
                REQ[i]                 = 1'b1;
                REQ_LAST[i]            = beat[8];
                REQ_DATA[i*WIDTH +: WIDTH] = beat[7:0];
            end
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic last);
        q[r].push_back({last, d});
    endtask

    task automatic expect_beat(input logic [1:0] id, input logic [7:0] d);
        exp_id.push_back(id);
        exp_data.push_back(d);
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_id.delete();
        exp_data.delete();
        exp_id.delete();
    endtask

    // Called at a negedge: log this cycle's write, advance one clock, let
    // producers retire acked beats, and return at the next negedge.
    task automatic step();
        ack_seen = REQ_ACK;
        if (FIFO_STROBE) begin
            log_data.push_back(FIFO_DATA);
            log_id.push_back(GRANT_ID);
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_seen[i] && q[i].size() > 0) begin
                void'(q[i].pop_front());
            end
        end
        drive();
        @(negedge CLK);
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (q[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while ((pending() || GRANT_VALID) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, log_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < log_data.size(); i++) begin
            check({tag, "_data"}, log_data[i], exp_data[i]);
            check({tag, "_id"}, log_id[i], exp_id[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] rr_data [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        logic [3:0] rr_ack  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        RESET_N   = 1'b0;
        FIFO_FULL = 1'b0;
        drive();
        @(negedge CLK);
        step();
        step();

        // Reset state
        check("rst_valid",  GRANT_VALID, 0);
        check("rst_id",     GRANT_ID,    0);
        check("rst_strobe", FIFO_STROBE, 0);
        check("rst_data",   FIFO_DATA,   0);
        check("rst_ack",    REQ_ACK,     0);

        // Single beat from requester 0
        RESET_N = 1'b1;
        load(0, 8'hA5, 1'b1);
        drive();
        #1;
        check("t1_arb_strobe", FIFO_STROBE, 0);
        check("t1_arb_valid",  GRANT_VALID, 0);
        step();
        check("t1_valid",  GRANT_VALID, 1);
        check("t1_id",     GRANT_ID,    0);
        check("t1_strobe", FIFO_STROBE, 1);
        check("t1_data",   FIFO_DATA,   8'hA5);
        check("t1_ack",    REQ_ACK,     4'b0001);
        step();
        check("t1_release", GRANT_VALID, 0);
        check("t1_quiet",   FIFO_STROBE, 0);

        // All four request single-beat packets: 0,1,2,3,0, two cycles per beat
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        load(0, 8'h10, 1'b1);
        load(1, 8'h11, 1'b1);
        load(2, 8'h12, 1'b1);
        load(3, 8'h13, 1'b1);
        load(0, 8'h14, 1'b1);
        drive();
        #1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2_valid", GRANT_VALID, 1);
            check("t2_id",    GRANT_ID,    rr_id[k]);
            check("t2_data",  FIFO_DATA,   rr_data[k]);
            check("t2_ack",   REQ_ACK,     rr_ack[k]);
            step();
            check("t2_arb_strobe", FIFO_STROBE, 0);
        end

        // 20-beat packet from 2 split at MAX_BURST, requester 0 served in between
        clear_logs();
        for (int i = 0; i < 20; i++) load(2, 8'(8'h40 + i), 1'(i == 19));
        load(0, 8'h99, 1'b1);
        drive();
        #1;
        for (int i = 0; i < 16; i++) expect_beat(2'd2, 8'(8'h40 + i));
        expect_beat(2'd0, 8'h99);
        for (int i = 16; i < 20; i++) expect_beat(2'd2, 8'(8'h40 + i));
        step();
        for (int i = 0; i < 16; i++) step();
        check("t3_forced_release", GRANT_VALID, 0);
        check("t3_beats_first",    log_data.size(), 16);
        check("t3_left_in_q2",     q[2].size(), 4);
        run_until_idle("t3", 100);
        compare_log("t3");

        // FIFO_FULL for 5 cycles mid-packet of requester 1
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            load(1, 8'(8'h60 + i), 1'(i == 5));
            expect_beat(2'd1, 8'(8'h60 + i));
        end
        drive();
        #1;
        step();
        step();
        step();
        FIFO_FULL = 1'b1;
        #1;
        for (int j = 0; j < 5; j++) begin
            check("t4_stall_strobe", FIFO_STROBE, 0);
            check("t4_stall_ack",    REQ_ACK,     0);
            check("t4_stall_id",     GRANT_ID,    1);
            check("t4_stall_valid",  GRANT_VALID, 1);
            check("t4_stall_cnt",    dut.beat_cnt, 2);
            step();
        end
        FIFO_FULL = 1'b0;
        #1;
        check("t4_resume_strobe", FIFO_STROBE, 1);
        check("t4_resume_data",   FIFO_DATA,   8'h62);
        check("t4_resume_id",     GRANT_ID,    1);
        run_until_idle("t4", 100);
        compare_log("t4");

        // Requester 2 abandons after 3 beats without LAST; 3 is next
        clear_logs();
        load(2, 8'h70, 1'b0);
        load(2, 8'h71, 1'b0);
        load(2, 8'h72, 1'b0);
        load(3, 8'h80, 1'b1);
        drive();
        #1;
        expect_beat(2'd2, 8'h70);
        expect_beat(2'd2, 8'h71);
        expect_beat(2'd2, 8'h72);
        expect_beat(2'd3, 8'h80);
        step();
        step();
        step();
        step();
        check("t5_drop_strobe", FIFO_STROBE, 0);
        check("t5_drop_valid",  GRANT_VALID, 1);
        step();
        check("t5_released", GRANT_VALID, 0);
        step();
        check("t5_next_id",   GRANT_ID,  3);
        check("t5_next_data", FIFO_DATA, 8'h80);
        run_until_idle("t5", 50);
        compare_log("t5");

        // Reset for one cycle during a burst of requester 1
        clear_logs();
        for (int i = 0; i < 8; i++) load(1, 8'(8'h90 + i), 1'(i == 7));
        drive();
        #1;
        step();
        step();
        RESET_N = 1'b0;
        #1;
        check("t6_rst_low_strobe", FIFO_STROBE, 0);
        check("t6_rst_low_ack",    REQ_ACK,     0);
        step();
        check("t6_rst_valid",  GRANT_VALID, 0);
        check("t6_rst_id",     GRANT_ID,    0);
        check("t6_rst_strobe", FIFO_STROBE, 0);
        check("t6_rst_data",   FIFO_DATA,   0);
        RESET_N = 1'b1;
        load(0, 8'hB0, 1'b1);
        drive();
        #1;
        step();
        check("t6_first_id",   GRANT_ID,  0);
        check("t6_first_data", FIFO_DATA, 8'hB0);
        expect_beat(2'd1, 8'h90);
        expect_beat(2'd0, 8'hB0);
        for (int i = 1; i < 8; i++) expect_beat(2'd1, 8'(8'h90 + i));
        run_until_idle("t6", 100);
        compare_log("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
